// File: rtl/alu_cmd_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode constants, driver state encoding and opcode
//                helpers for the ALU command driver and its reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_PARITY   = 3'b000;
    localparam logic [2:0] OP_POPCOUNT = 3'b001;
    localparam logic [2:0] OP_ROTR     = 3'b010;
    localparam logic [2:0] OP_ROTL     = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } drv_state_e;

    // Opcodes 1xx are reserved and never issued to the ALU.
    function automatic logic is_reserved(input logic [2:0] opcode);
        return opcode[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_driver_ref_model.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ref_model
//  Description : Combinational expected-result function for the ALU
//                (PARITY, POPCOUNT, ROTR, ROTL). Reserved opcodes give 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 1024
) (
    input  logic [2:0]            i_opcode,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int                    c_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] c_DW    = DATA_WIDTH'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] w_amt;
    logic [DATA_WIDTH-1:0] w_inv_amt;
    logic [c_CNT_W-1:0]    w_pop;

    // Rotate amount is B modulo the width; the complementary shift handles
    // the wrap, and a zero amount shifts the complement fully out.
    assign w_amt     = i_b % c_DW;
    assign w_inv_amt = c_DW - w_amt;

    // Population count of operand A.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_pop = w_pop + c_CNT_W'(i_a[i]);
        end
    end

    // Opcode select.
    always_comb begin
        o_result = '0;
        case (i_opcode)
            OP_PARITY:   o_result = {{(DATA_WIDTH-1){1'b0}}, ^i_a};
            OP_POPCOUNT: o_result = DATA_WIDTH'(w_pop);
            OP_ROTR:     o_result = (i_a >> w_amt) | (i_a << w_inv_amt);
            OP_ROTL:     o_result = (i_a << w_amt) | (i_a >> w_inv_amt);
            default:     o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_driver
//  Description : Initiator for a registered ALU. Accepts one command over a
//                valid/ready port, drives opcode/A/B, waits ALU_LAT edges,
//                captures the result and returns it with the tag over a
//                valid/ready response port. Reserved opcodes return an error
//                without touching the ALU.
//  Options     : ALU_DRV_CHECK_EN - compare each result against an internal
//                model, flag rsp_mismatch and keep a saturating count.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int TAG_W      = 4,
    parameter int ALU_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_opcode,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic [TAG_W-1:0]      cmd_tag,
    output logic [2:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  rsp_err,
    output logic                  rsp_mismatch,
    output logic [15:0]           mismatch_cnt,
    output logic                  busy
);

    localparam int               c_CNT_W = 4;
    localparam logic [c_CNT_W-1:0] c_LAT = c_CNT_W'(ALU_LAT);

    drv_state_e            state_q,      state_d;
    logic [c_CNT_W-1:0]    cnt_q,        cnt_d;
    logic [2:0]            alu_opcode_q, alu_opcode_d;
    logic [DATA_WIDTH-1:0] alu_a_q,      alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q,      alu_b_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,   rsp_data_d;
    logic [TAG_W-1:0]      rsp_tag_q,    rsp_tag_d;
    logic                  rsp_err_q,    rsp_err_d;

    logic w_accept;
    logic w_capture;

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_capture  = (state_q == WAIT) && (cnt_q == '0);

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;

    // Next-state and datapath: issue on accept, count down the ALU latency,
    // capture, then hold the response until the consumer takes it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    rsp_tag_d = cmd_tag;
                    if (is_reserved(cmd_opcode)) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = RESP;
                    end else begin
                        alu_opcode_d = cmd_opcode;
                        alu_a_d      = cmd_a;
                        alu_b_d      = cmd_b;
                        cnt_d        = c_LAT;
                        state_d      = WAIT;
                    end
                end
            end
            WAIT: begin
                if (w_capture) begin
                    rsp_data_d = alu_result;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_opcode_q <= 3'b000;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_data_q   <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

`ifdef ALU_DRV_CHECK_EN
    logic [DATA_WIDTH-1:0] w_model;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  rsp_mismatch_q, rsp_mismatch_d;
    logic [15:0]           mismatch_cnt_q, mismatch_cnt_d;

    alu_ref_model #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ref_model (
        .i_opcode (cmd_opcode),
        .i_a      (cmd_a),
        .i_b      (cmd_b),
        .o_result (w_model)
    );

    // Snapshot the expected value at accept (cmd_* may change afterwards),
    // compare at capture; reserved opcodes never reach the comparison.
    always_comb begin
        exp_d          = exp_q;
        rsp_mismatch_d = rsp_mismatch_q;
        mismatch_cnt_d = mismatch_cnt_q;
        if (w_accept) begin
            exp_d = w_model;
            if (is_reserved(cmd_opcode)) begin
                rsp_mismatch_d = 1'b0;
            end
        end
        if (w_capture) begin
            rsp_mismatch_d = (alu_result != exp_q);
            if ((alu_result != exp_q) && (mismatch_cnt_q != 16'hFFFF)) begin
                mismatch_cnt_d = mismatch_cnt_q + 16'd1;
            end
        end
    end

    // Checker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q          <= '0;
            rsp_mismatch_q <= 1'b0;
            mismatch_cnt_q <= '0;
        end else begin
            exp_q          <= exp_d;
            rsp_mismatch_q <= rsp_mismatch_d;
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    assign rsp_mismatch = rsp_mismatch_q;
    assign mismatch_cnt = mismatch_cnt_q;
`else
    assign rsp_mismatch = 1'b0;
    assign mismatch_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_driver
//  Description : Self-checking bench for alu_cmd_driver with a one-stage ALU
//                stub (optionally corrupting bit 0) and a behavioural model.
//  Options     : ALU_DRV_CHECK_EN - expects mismatch flag/count activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int DW  = 1024;
    localparam int TW  = 4;
    localparam int LAT = 1;
`ifdef ALU_DRV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_opcode = 3'b000;
    logic [DW-1:0] cmd_a = '0;
    logic [DW-1:0] cmd_b = '0;
    logic [TW-1:0] cmd_tag = '0;
    logic [2:0]    alu_opcode;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_err;
    logic          rsp_mismatch;
    logic [15:0]   mismatch_cnt;
    logic          busy;

    logic          stub_xor = 1'b0;
    logic [DW-1:0] w_stub;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    logic [2:0]    last_op = 3'b000;
    logic [DW-1:0] last_a  = '0;
    logic [DW-1:0] last_b  = '0;

    always #5 clk = ~clk;

    alu_cmd_driver #(
        .DATA_WIDTH (DW),
        .TAG_W      (TW),
        .ALU_LAT    (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .rsp_err      (rsp_err),
        .rsp_mismatch (rsp_mismatch),
        .mismatch_cnt (mismatch_cnt),
        .busy         (busy)
    );

    // Registered ALU stub, one edge of latency, optional bit-0 corruption.
    alu_ref_model #(.DATA_WIDTH(DW)) u_stub (
        .i_opcode (alu_opcode),
        .i_a      (alu_a),
        .i_b      (alu_b),
        .o_result (w_stub)
    );
    always @(posedge clk) alu_result <= w_stub ^ {{(DW-1){1'b0}}, stub_xor};

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h..%h expected=%h..%h", tag,
                   obs[DW-1 -: 32], obs[31:0], exp[DW-1 -: 32], exp[31:0]);
        end
    endtask

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural model written from the operation definitions.
    function automatic logic [DW-1:0] model(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic [DW-1:0] bm;
        int ones;
        int amt;
        r    = '0;
        ones = 0;
        for (int i = 0; i < DW; i++) if (a[i]) ones++;
        bm  = b % DW;
        amt = int'(bm[31:0]);
        case (op)
            OP_PARITY:   r[0] = ((ones % 2) == 1);
            OP_POPCOUNT: r[31:0] = ones;
            OP_ROTR:     for (int i = 0; i < DW; i++) r[i] = a[(i + amt) % DW];
            OP_ROTL:     for (int i = 0; i < DW; i++) r[(i + amt) % DW] = a[i];
            default:     r = '0;
        endcase
        return r;
    endfunction

    task automatic check_reset_values();
        chk("rst_rsp_valid", rsp_valid, 0);
        chkw("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_mismatch", rsp_mismatch, 0);
        chk("rst_mismatch_cnt", mismatch_cnt, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chkw("rst_alu_a", alu_a, '0);
        chkw("rst_alu_b", alu_b, '0);
        chk("rst_busy", busy, 0);
    endtask

    // One command from accept to response handshake; exp_data is the value
    // the ALU stub is expected to deliver (ignored for reserved opcodes).
    task automatic run_cmd(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [TW-1:0] tag, input logic [DW-1:0] exp_data, input int hold);
        logic          resv;
        logic          exp_mis;
        logic [DW-1:0] exp_rsp;
        int            k;
        bit            seen;
        resv    = op[2];
        exp_rsp = resv ? '0 : exp_data;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_tag    = tag;
        rsp_ready  = 1'b0;
        @(posedge clk);
        if (!resv) begin
            last_op = op;
            last_a  = a;
            last_b  = b;
        end
        exp_mis = CHK && !resv && stub_xor;
        if (exp_mis && exp_cnt < 65535) exp_cnt++;
        seen = 0;
        k    = 0;
        while (k < 40) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                break;
            end
            chk("wait_cmd_ready", cmd_ready, 0);
            chk("wait_busy", busy, 1);
            chk("wait_alu_opcode", alu_opcode, last_op);
            chkw("wait_alu_a", alu_a, last_a);
            chkw("wait_alu_b", alu_b, last_b);
            // Noise on the command port while busy must be ignored.
            cmd_valid  = 1'b1;
            cmd_opcode = 3'($urandom);
            cmd_a      = rand_vec();
            cmd_b      = rand_vec();
            cmd_tag    = TW'($urandom);
            k++;
        end
        cmd_valid = 1'b0;
        chk("rsp_seen", seen, 1);
        chk("rsp_latency", k, resv ? 0 : LAT + 1);
        chkw("rsp_data", rsp_data, exp_rsp);
        chk("rsp_tag", rsp_tag, tag);
        chk("rsp_err", rsp_err, resv);
        chk("rsp_mismatch", rsp_mismatch, exp_mis);
        chk("mismatch_cnt", mismatch_cnt, exp_cnt);
        chk("rsp_alu_opcode", alu_opcode, last_op);
        chkw("rsp_alu_a", alu_a, last_a);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_cmd_ready", cmd_ready, 0);
            chkw("hold_rsp_data", rsp_data, exp_rsp);
            chk("hold_rsp_tag", rsp_tag, tag);
            chk("hold_rsp_err", rsp_err, resv);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    logic [DW-1:0] ve;
    logic [2:0]    vop;

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_cmd_ready", cmd_ready, 1);

        // Directed operations.
        va = '0; va[7:0] = 8'hAC;
        run_cmd(OP_PARITY, va, '0, 4'd3, '0, 0);
        va = '0; va[7:0] = 8'hED; ve = '0; ve[7:0] = 8'd6;
        run_cmd(OP_POPCOUNT, va, '0, 4'd5, ve, 1);
        va = '0; va[7:0] = 8'hAD; ve = '0; ve[7:0] = 8'd5;
        run_cmd(OP_POPCOUNT, va, '0, 4'd6, ve, 0);
        va = '0; va[7:0] = 8'hAD; vb = '0; vb[1:0] = 2'd3;
        ve = '0; ve[DW-1 -: 3] = 3'b101; ve[7:0] = 8'h15;
        run_cmd(OP_ROTR, va, vb, 4'd7, ve, 2);
        va = '0; va[DW-1 -: 8] = 8'hAD;
        ve = '0; ve[DW-1 -: 8] = 8'h68; ve[2:0] = 3'b101;
        run_cmd(OP_ROTL, va, vb, 4'd8, ve, 0);

        // Reserved opcode with a stalled consumer.
        run_cmd(3'b101, rand_vec(), rand_vec(), 4'd9, '0, 5);

        // Reset during WAIT drops the command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = OP_POPCOUNT; cmd_a = rand_vec(); cmd_tag = 4'd10;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        last_op = 3'b000; last_a = '0; last_b = '0; exp_cnt = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("after_rst_rsp_valid", rsp_valid, 0);
        end
        rsp_ready = 1'b0;

        // Corrupted ALU result.
        stub_xor = 1'b1;
        va = '0; va[7:0] = 8'hED; ve = '0; ve[7:0] = 8'd7;
        run_cmd(OP_POPCOUNT, va, '0, 4'd11, ve, 0);
        stub_xor = 1'b0;

        // Randomized commands against the behavioural model.
        for (int n = 0; n < 14; n++) begin
            vop = 3'($urandom_range(0, 4));
            if (vop == 3'd4) vop = 3'($urandom_range(4, 7));
            va = rand_vec();
            if ($urandom_range(0, 1) == 1) begin
                vb = '0;
                vb[15:0] = 16'($urandom_range(0, 3000));
            end else begin
                vb = rand_vec();
            end
            stub_xor = ($urandom_range(0, 3) == 0);
            ve = model(vop, va, vb) ^ {{(DW-1){1'b0}}, stub_xor};
            run_cmd(vop, va, vb, TW'($urandom), ve, int'($urandom_range(0, 2)));
        end
        stub_xor = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
